img_readout_checker: RTL



---
 rtl/img_readout_checker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/img_readout_checker.sv
// Framing and test-pattern checker for the ImgController readout stream (header/pixels/checksum/padding).
// Status reflects an accepted word one cycle later; no backpressure, in_valid may be high every cycle.
module img_readout_checker #(
    parameter int          HeaderWordCount  = 32,
    parameter int          ImgWidth         = 16,
    parameter int          ImgHeight        = 16,
    parameter int          PaddingWordCount = 3,
    parameter int          PixelWidth       = 12,
    parameter logic [15:0] PixelInitial     = 16'h0FFF,
    parameter int          PixelDelta       = -1,
    parameter int          ThumbPeriod      = 8,
    parameter int          ThumbKeep        = 2,
    localparam int         NFull            = HeaderWordCount + ImgWidth*ImgHeight + 2 + PaddingWordCount,
    localparam int         IdxW             = $clog2(NFull)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_start_i,
    input  logic            cmd_thumb_i,
    input  logic            in_valid_i,
    input  logic [15:0]     in_data_i,
    output logic            status_busy_o,
    output logic            status_done_o,
    output logic            status_ok_o,
    output logic [15:0]     status_errCount_o,
    output logic [IdxW-1:0] status_firstErrIdx_o,
    output logic [IdxW:0]   status_wordCount_o,
    output logic            status_overrun_o
);

    localparam int ThW    = ImgWidth  * ThumbKeep / ThumbPeriod;
    localparam int ThH    = ImgHeight * ThumbKeep / ThumbPeriod;
    localparam int NThumb = HeaderWordCount + ThW*ThH + 2 + PaddingWordCount;
    localparam int CntW   = IdxW + 1;
    localparam int XW     = $clog2(ImgWidth + 1);
    localparam int YW     = $clog2(ImgHeight + 1);
    localparam int KW     = $clog2(ThumbKeep + 1);
    localparam int Skip   = ThumbPeriod - ThumbKeep + 1;

    localparam logic [XW-1:0]   FULL_X_LAST  = XW'(ImgWidth - 1);
    localparam logic [XW-1:0]   THUMB_X_LAST = XW'(ThW - 1);
    localparam logic [YW-1:0]   FULL_Y_LAST  = YW'(ImgHeight - 1);
    localparam logic [YW-1:0]   THUMB_Y_LAST = YW'(ThH - 1);
    localparam logic [KW-1:0]   KEEP_LAST    = KW'(ThumbKeep - 1);
    localparam logic [CntW-1:0] HDR_LAST     = CntW'(HeaderWordCount - 1);
    localparam logic [CntW-1:0] FULL_LAST    = CntW'(NFull - 1);
    localparam logic [CntW-1:0] THUMB_LAST   = CntW'(NThumb - 1);
    localparam bit              HAS_HDR      = (HeaderWordCount > 0);
    localparam bit              HAS_PAD      = (PaddingWordCount > 0);

    // Pattern steps, all reduced modulo 2^PixelWidth at elaboration time.
    localparam logic [PixelWidth-1:0] PIX_INIT = PixelInitial[PixelWidth-1:0];
    localparam logic [PixelWidth-1:0] COL_STEP = PixelWidth'(PixelDelta);
    localparam logic [PixelWidth-1:0] COL_JUMP = PixelWidth'(PixelDelta * Skip);
    localparam logic [PixelWidth-1:0] ROW_STEP = PixelWidth'(PixelDelta * ImgWidth);
    localparam logic [PixelWidth-1:0] ROW_JUMP = PixelWidth'(PixelDelta * ImgWidth * Skip);
    localparam logic [15:0]           PIX_MASK = 16'((32'd1 << PixelWidth) - 32'd1);

    typedef enum logic [2:0] {
        IDLE, HEADER, PIXELS, CHECKSUM, PADDING, DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  thumb_q, thumb_d;
    logic [CntW-1:0]       wc_q, wc_d;
    logic [15:0]           err_q, err_d;
    logic [IdxW-1:0]       first_q, first_d;
    logic                  ovr_q, ovr_d;
    logic [31:0]           sum_q, sum_d;
    logic [PixelWidth-1:0] exp_q, exp_d;
    logic [PixelWidth-1:0] rowb_q, rowb_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [KW-1:0]         kc_q, kc_d;
    logic [KW-1:0]         kr_q, kr_d;
    logic                  cs_hi_q, cs_hi_d;
    logic                  err_now;

    logic [XW-1:0]   x_last;
    logic [YW-1:0]   y_last;
    logic [CntW-1:0] wc_last;
    logic [15:0]     cs_exp;

    assign x_last  = thumb_q ? THUMB_X_LAST : FULL_X_LAST;
    assign y_last  = thumb_q ? THUMB_Y_LAST : FULL_Y_LAST;
    assign wc_last = thumb_q ? THUMB_LAST   : FULL_LAST;
    assign cs_exp  = cs_hi_q ? sum_q[31:16] : sum_q[15:0];

    always_comb begin
        state_d = state_q;
        thumb_d = thumb_q;
        wc_d    = wc_q;
        err_d   = err_q;
        first_d = first_q;
        ovr_d   = ovr_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        rowb_d  = rowb_q;
        x_d     = x_q;
        y_d     = y_q;
        kc_d    = kc_q;
        kr_d    = kr_q;
        cs_hi_d = cs_hi_q;
        err_now = 1'b0;

        if (cmd_start_i) begin
            // Restart wins over any word presented in the same cycle.
            state_d = HAS_HDR ? HEADER : PIXELS;
            thumb_d = cmd_thumb_i;
            wc_d    = '0;
            err_d   = '0;
            first_d = '0;
            ovr_d   = 1'b0;
            sum_d   = '0;
            exp_d   = PIX_INIT;
            rowb_d  = PIX_INIT;
            x_d     = '0;
            y_d     = '0;
            kc_d    = '0;
            kr_d    = '0;
            cs_hi_d = 1'b0;
        end else if (in_valid_i) begin
            unique case (state_q)
                HEADER: begin
                    wc_d  = wc_q + 1'b1;
                    sum_d = sum_q + {16'h0, in_data_i};
                    if (wc_q == HDR_LAST) state_d = PIXELS;
                end
                PIXELS: begin
                    wc_d    = wc_q + 1'b1;
                    sum_d   = sum_q + {16'h0, in_data_i};
                    err_now = ((in_data_i & ~PIX_MASK) != 16'h0) ||
                              (in_data_i[PixelWidth-1:0] != exp_q);
                    if (x_q == x_last) begin
                        // Row end: next expected value restarts from the next (kept) sensor row.
                        rowb_d = rowb_q + ((thumb_q && kr_q == KEEP_LAST) ? ROW_JUMP : ROW_STEP);
                        exp_d  = rowb_d;
                        x_d    = '0;
                        kc_d   = '0;
                        y_d    = y_q + 1'b1;
                        kr_d   = (kr_q == KEEP_LAST) ? '0 : kr_q + 1'b1;
                        if (y_q == y_last) begin
                            state_d = CHECKSUM;
                            cs_hi_d = 1'b0;
                        end
                    end else begin
                        exp_d = exp_q + ((thumb_q && kc_q == KEEP_LAST) ? COL_JUMP : COL_STEP);
                        x_d   = x_q + 1'b1;
                        kc_d  = (kc_q == KEEP_LAST) ? '0 : kc_q + 1'b1;
                    end
                end
                CHECKSUM: begin
                    wc_d    = wc_q + 1'b1;
                    err_now = (in_data_i != cs_exp);
                    cs_hi_d = 1'b1;
                    if (cs_hi_q) state_d = HAS_PAD ? PADDING : DONE;
                end
                PADDING: begin
                    wc_d = wc_q + 1'b1;
                    if (wc_q == wc_last) state_d = DONE;
                end
                DONE: begin
                    ovr_d = 1'b1;
                end
                default: ;
            endcase

            if (err_now) begin
                if (err_q == 16'h0) first_d = wc_q[IdxW-1:0];
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            thumb_q <= 1'b0;
            wc_q    <= '0;
            err_q   <= '0;
            first_q <= '0;
            ovr_q   <= 1'b0;
            sum_q   <= '0;
            exp_q   <= '0;
            rowb_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            kc_q    <= '0;
            kr_q    <= '0;
            cs_hi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            thumb_q <= thumb_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            first_q <= first_d;
            ovr_q   <= ovr_d;
            sum_q   <= sum_d;
            exp_q   <= exp_d;
            rowb_q  <= rowb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kc_q    <= kc_d;
            kr_q    <= kr_d;
            cs_hi_q <= cs_hi_d;
        end
    end

    assign status_busy_o        = (state_q != IDLE) && (state_q != DONE);
    assign status_done_o        = (state_q == DONE);
    assign status_ok_o          = (state_q == DONE) && (err_q == 16'h0) && !ovr_q;
    assign status_errCount_o    = err_q;
    assign status_firstErrIdx_o = first_q;
    assign status_wordCount_o   = wc_q;
    assign status_overrun_o     = ovr_q;

endmodule
